// File: rtl/fp_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pe_pkg
//  Description : Shared constants, PE precision-mode encoding and the
//                lane-count helper for the 3-mode floating-point PE.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pe_pkg;

  localparam int SUM_W        = 66;  // un-normalized sum width
  localparam int POS_W        = 7;   // LZD position / leading-zero count width
  localparam int LZD_ZERO_POS = 66;  // LZD output when no bit is set

  typedef enum logic [1:0] {
    MODE_FP64 = 2'd0,
    MODE_FP32 = 2'd1,
    MODE_FP16 = 2'd2
  } mode_e;

  // Number of active lanes for a given precision mode; the reserved
  // encoding enables no lane at all.
  function automatic logic [2:0] lanes_of(input logic [1:0] mode);
    case (mode)
      MODE_FP64: return 3'd1;
      MODE_FP32: return 3'd2;
      MODE_FP16: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzd66.sv
`default_nettype none
// ============================================================================
//  Module      : lzd66
//  Description : Leading-zero detector for the 66-bit PE sum. Reports the
//                1-based position of the first set bit counted from the MSB
//                (1 = MSB set, 66 = only LSB set). An all-zero input also
//                reports 66; the caller disambiguates with a zero compare.
//  Ports       : i_data  in  SUM_W  value to scan
//                o_pos   out POS_W  1-based leading-one position
//  Revision    : 1.0  initial release
// ============================================================================
module lzd66
  import fp_pe_pkg::*;
(
  input  logic [SUM_W-1:0] i_data,
  output logic [POS_W-1:0] o_pos
);

  // Scan upward from the LSB so the highest set bit is the last to write.
  always_comb begin
    o_pos = POS_W'(LZD_ZERO_POS);
    for (int i = 0; i < SUM_W; i++) begin
      if (i_data[i]) begin
        o_pos = POS_W'(SUM_W - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : NREQ-wide round-robin arbiter. The search starts at the
//                lane after i_ptr and wraps; the first requester wins.
//  Ports       : i_req      in  NREQ   request vector
//                i_ptr      in  IDX_W  last granted lane
//                o_grant    out NREQ   one-hot grant
//                o_gnt_idx  out IDX_W  index of granted lane
//                o_gnt_any  out 1      some lane is granted
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  int w_idx;

  always_comb begin
    o_grant   = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NREQ;
      if (!o_gnt_any && i_req[w_idx]) begin
        o_gnt_any        = 1'b1;
        o_grant[w_idx]   = 1'b1;
        o_gnt_idx        = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lzd_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lzd_norm_arbiter
//  Description : Shares one 66-bit LZD among up to four PE lanes. A request
//                is arbitrated round-robin into stage s1 (LZD), then into the
//                output register with the normalizing left shift applied.
//  Ports       : clk        in   1            rising-edge clock
//                rst_n      in   1            async active-low reset
//                cfg_mode   in   2            0=FP64 1=FP32 2=FP16 3=none
//                req_valid  in   NREQ         per-lane request valid
//                req_ready  out  NREQ         per-lane accept (one-hot or 0)
//                req_sum    in   NREQ*SUM_W   lane i at [i*SUM_W +: SUM_W]
//                out_valid  out  1            result valid
//                out_ready  in   1            downstream accept
//                out_lane   out  2            lane id of result
//                out_lzc    out  POS_W        leading zeros (66 when zero)
//                out_zero   out  1            sum was zero
//                out_norm   out  SUM_W        normalized sum
//  Revision    : 1.0  initial release
// ============================================================================
module lzd_norm_arbiter
  import fp_pe_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cfg_mode,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*SUM_W-1:0]  req_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_lane,
  output logic [POS_W-1:0]       out_lzc,
  output logic                   out_zero,
  output logic [SUM_W-1:0]       out_norm
);

  localparam int IDX_W = 2;

  // ---------------------------------------------------------------- state
  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_lane;
  logic [SUM_W-1:0]  r_s1_sum;
  logic [IDX_W-1:0]  r_rr_ptr;

  // ---------------------------------------------------------------- wires
  logic [2:0]        w_lanes;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_grant;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_s1_adv;
  logic              w_s1_can_load;
  logic              w_accept;
  logic [POS_W-1:0]  w_pos;
  logic              w_s1_zero;
  logic [POS_W-1:0]  w_lzc;
  logic [SUM_W-1:0]  w_norm;

  assign w_lanes = lanes_of(cfg_mode);

  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign w_elig[i] = req_valid[i] && (3'(i) < w_lanes);
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req     (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_grant),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign w_s1_adv      = r_s1_valid && (!out_valid || out_ready);
  assign w_s1_can_load = !r_s1_valid || w_s1_adv;
  // The grant only exists for an eligible (hence valid) lane, so a load
  // opportunity with a grant is an accept.
  assign w_accept      = w_gnt_any && w_s1_can_load;
  // Ready is forced low for the whole reset window, not only after an edge.
  assign req_ready     = (w_accept && rst_n) ? w_grant : '0;

  // ---------------------------------------------------------------- s1 LZD
  lzd66 u_lzd (
    .i_data (r_s1_sum),
    .o_pos  (w_pos)
  );

  // pos=66 covers both sum==1 and sum==0; the explicit compare splits them.
  assign w_s1_zero = (r_s1_sum == '0);
  assign w_lzc     = w_s1_zero ? POS_W'(LZD_ZERO_POS) : (w_pos - POS_W'(1));
  assign w_norm    = w_s1_zero ? '0 : (r_s1_sum << w_lzc);

  // ---------------------------------------------------------------- regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lane  <= '0;
      r_s1_sum   <= '0;
      r_rr_ptr   <= IDX_W'(NREQ - 1);
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_lane  <= w_gnt_idx;
        r_s1_sum   <= req_sum[w_gnt_idx*SUM_W +: SUM_W];
        r_rr_ptr   <= w_gnt_idx;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
    end else begin
      if (w_s1_adv) begin
        out_valid <= 1'b1;
        out_lane  <= r_s1_lane;
        out_lzc   <= w_lzc;
        out_zero  <= w_s1_zero;
        out_norm  <= w_norm;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
